// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - single-port word RAM responder with parameterised access latency
// Reports FREE/BUSY/ACCESS/ERROR on ramstate; aborts when the held request changes or drops.

module ram_responder #(
   parameter int ADDR_W = 10,
   parameter int LAT    = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ramREN,
   input  logic        ramWEN,
   input  logic [31:0] ramaddr,
   input  logic [31:0] ramstore,
   output logic [31:0] ramload,
   output logic [1:0]  ramstate
);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic [ADDR_W-1:0]   cap_idx;
   logic                cap_wen;
   logic [31:0]         mem [0:(1<<ADDR_W)-1];

   logic                req;
   logic                illegal;
   logic                abort;
   logic                do_access;
   logic                do_write;
   logic [ADDR_W-1:0]   idx;
   logic                unused_bits;

   assign unused_bits = ^ramaddr[1:0];
   assign ramstate    = state;

   always_comb begin
      req       = ramREN | ramWEN;
      idx       = ramaddr[ADDR_W+1:2];
      illegal   = (ramREN & ramWEN) | (|ramaddr[31:ADDR_W+2]);
      // A held request must match what was captured on entry to BUSY, else abort.
      abort     = !req || illegal || (idx != cap_idx) || (ramWEN != cap_wen);
      do_access = 1'b0;
      if (state == FREE && req && !illegal && LAT == 0)
         do_access = 1'b1;
      if (state == BUSY && !abort && cnt == 4'd0)
         do_access = 1'b1;
      do_write  = do_access & ramWEN;
   end

   // Array is not reset; a write racing an asserted reset is suppressed.
   always_ff @(posedge CLK) begin
      if (do_write && !RST)
         mem[idx] <= ramstore;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= FREE;
         cnt     <= 4'd0;
         cap_idx <= '0;
         cap_wen <= 1'b0;
         ramload <= 32'h0;
      end else begin
         if (do_access && !ramWEN)
            ramload <= mem[idx];
         case (state)
            FREE: begin
               if (req) begin
                  if (illegal) begin
                     state <= ERROR;
                  end else begin
                     cap_idx <= idx;
                     cap_wen <= ramWEN;
                     if (LAT == 0) begin
                        state <= ACCESS;
                     end else begin
                        state <= BUSY;
                        cnt   <= 4'(LAT - 1);
                     end
                  end
               end
            end
            BUSY: begin
               if (abort) begin
                  state <= FREE;
                  cnt   <= 4'd0;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= ACCESS;
               end
            end
            ACCESS:  state <= FREE;
            default: state <= FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard bench for ram_responder at LAT=2, LAT=0 and LAT=3
// Stimulus pushes expected ACCESS/ERROR events; a negedge monitor pops and compares them.

module tb_ram_responder;

   localparam logic [1:0] S_FREE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   typedef struct {
      int          dut;
      logic [1:0]  st;
      logic [31:0] load;
      int          cyc;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        ren   [3];
   logic        wen   [3];
   logic [31:0] addr  [3];
   logic [31:0] store [3];
   logic [31:0] load  [3];
   logic [1:0]  st    [3];

   int          lat_of [3] = '{2, 0, 3};
   logic [31:0] last_load [3];
   exp_t        sbq [$];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   ram_responder #(.ADDR_W(10), .LAT(2)) u0 (
      .CLK(CLK), .RST(RST), .ramREN(ren[0]), .ramWEN(wen[0]), .ramaddr(addr[0]),
      .ramstore(store[0]), .ramload(load[0]), .ramstate(st[0]));
   ram_responder #(.ADDR_W(10), .LAT(0)) u1 (
      .CLK(CLK), .RST(RST), .ramREN(ren[1]), .ramWEN(wen[1]), .ramaddr(addr[1]),
      .ramstore(store[1]), .ramload(load[1]), .ramstate(st[1]));
   ram_responder #(.ADDR_W(10), .LAT(3)) u2 (
      .CLK(CLK), .RST(RST), .ramREN(ren[2]), .ramWEN(wen[2]), .ramaddr(addr[2]),
      .ramstore(store[2]), .ramload(load[2]), .ramstate(st[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      for (int d = 0; d < 3; d++) begin
         if (!RST && (st[d] == S_ACC || st[d] == S_ERR)) begin
            if (sbq.size() == 0) begin
               check("unexpected_event", {30'd0, st[d]}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("event_dut", d, e.dut);
               check("event_state", {30'd0, st[d]}, {30'd0, e.st});
               check("event_cycle", cyc, e.cyc);
               check("event_load", load[d], e.load);
            end
         end
      end
   end

   task automatic xact(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] data, input logic [1:0] est,
                       input logic [31:0] eload, input int ecyc);
      exp_t e;
      int   busy;
      bit   done;
      e.dut  = d;
      e.st   = est;
      e.load = eload;
      e.cyc  = ecyc;
      sbq.push_back(e);
      ren[d] = r; wen[d] = w; addr[d] = a; store[d] = data;
      busy = 0;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge CLK);
         if (st[d] == S_BUSY) busy++;
         else if (st[d] == S_ACC || st[d] == S_ERR) done = 1;
      end
      ren[d] = 1'b0;
      wen[d] = 1'b0;
      check("timeout", {31'd0, done}, 32'd1);
      check("busy_cycles", busy, (est == S_ACC) ? lat_of[d] : 0);
      @(posedge CLK); #1;
      check("free_after", {30'd0, st[d]}, {30'd0, S_FREE});
   endtask

   task automatic wr(input int d, input logic [31:0] a, input logic [31:0] data, input int ecyc);
      xact(d, 1'b0, 1'b1, a, data, S_ACC, last_load[d], (ecyc < 0) ? cyc + lat_of[d] + 1 : ecyc);
   endtask

   task automatic rd(input int d, input logic [31:0] a, input logic [31:0] exp, input int ecyc);
      xact(d, 1'b1, 1'b0, a, 32'h0, S_ACC, exp, (ecyc < 0) ? cyc + lat_of[d] + 1 : ecyc);
      last_load[d] = exp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      for (int d = 0; d < 3; d++) begin
         ren[d] = 1'b0; wen[d] = 1'b0; addr[d] = 32'h0; store[d] = 32'h0;
         last_load[d] = 32'h0;
      end
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      for (int d = 0; d < 3; d++) begin
         check("reset_state", {30'd0, st[d]}, {30'd0, S_FREE});
         check("reset_load", load[d], 32'h0);
      end
      @(negedge CLK) RST = 1'b0;
      @(posedge CLK); #1;

      // LAT=2 write then read
      wr(0, 32'h40, 32'hDEADBEEF, -1);
      rd(0, 32'h40, 32'hDEADBEEF, -1);

      // LAT=0 write, read, read with ignored byte offset
      wr(1, 32'h44, 32'h12345678, -1);
      rd(1, 32'h44, 32'h12345678, -1);
      rd(1, 32'h46, 32'h12345678, -1);

      // Aborts on LAT=2
      wr(0, 32'h80, 32'hCAFEF00D, -1);
      wen[0] = 1'b1; addr[0] = 32'h80; store[0] = 32'h11111111;
      @(posedge CLK); #1;
      check("abort1_busy", {30'd0, st[0]}, {30'd0, S_BUSY});
      wen[0] = 1'b0;
      @(posedge CLK); #1;
      check("abort1_free", {30'd0, st[0]}, {30'd0, S_FREE});
      @(posedge CLK); #1;
      wen[0] = 1'b1; addr[0] = 32'h80; store[0] = 32'h22222222;
      @(posedge CLK); #1;
      check("abort2_busy", {30'd0, st[0]}, {30'd0, S_BUSY});
      addr[0] = 32'h84;
      @(posedge CLK); #1;
      check("abort2_free", {30'd0, st[0]}, {30'd0, S_FREE});
      wen[0] = 1'b0;
      @(posedge CLK); #1;
      rd(0, 32'h80, 32'hCAFEF00D, -1);

      // Errors: both strobes, then out-of-range address
      xact(0, 1'b1, 1'b1, 32'h40, 32'h0, S_ERR, last_load[0], cyc + 1);
      xact(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, S_ERR, last_load[0], cyc + 1);

      // Reset during BUSY of a write
      wr(0, 32'h10, 32'h5A5A0001, -1);
      rd(0, 32'h10, 32'h5A5A0001, -1);
      wen[0] = 1'b1; addr[0] = 32'h10; store[0] = 32'hA5A5A5A5;
      @(posedge CLK); #1;
      check("rst_pre_busy", {30'd0, st[0]}, {30'd0, S_BUSY});
      #1 RST = 1'b1;
      #1;
      check("rst_async_state", {30'd0, st[0]}, {30'd0, S_FREE});
      check("rst_async_load", load[0], 32'h0);
      wen[0] = 1'b0;
      for (int d = 0; d < 3; d++) last_load[d] = 32'h0;
      @(negedge CLK) RST = 1'b0;
      @(posedge CLK); #1;
      rd(0, 32'h10, 32'h5A5A0001, -1);

      // LAT=3 streaming: each access every 5 cycles
      t0 = cyc;
      for (int i = 0; i < 8; i++)
         wr(2, 32'(4 * i), 32'(i) * 32'h01010101, t0 + 4 + 5 * i);
      for (int i = 0; i < 8; i++)
         rd(2, 32'(4 * i), 32'(i) * 32'h01010101, t0 + 4 + 5 * (8 + i));

      repeat (3) @(posedge CLK);
      #1;
      check("scoreboard_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
